// File: rtl/rf_ctrl_pkg.sv
// Shared register-file control types: widths, address/data types and the
// write-source tag, plus the x0-masked one-hot decode used by the scoreboard.
package rf_ctrl_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREGS  = 1 << REG_AW;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]   xlen_t;

   typedef enum logic {
      SRC_WB  = 1'b0,
      SRC_MDU = 1'b1
   } src_t;

   // x0 never decodes, so it can never become busy
   function automatic logic [NREGS-1:0] reg_onehot(input reg_addr_t addr, input logic en);
      logic [NREGS-1:0] vec;
      vec = '0;
      if (en && (addr != '0)) begin
         vec[addr] = 1'b1;
      end else begin
         vec = '0;
      end
      return vec;
   endfunction

endpackage

// File: rtl/rf_wr_scheduler_if.sv
// Bundle of the WB/MDU write requests, MDU issue, hazard read ports and the
// register-file write port seen by the write scheduler.
interface rf_wr_scheduler_if;
   import rf_ctrl_pkg::*;

   logic      wb_valid;
   logic      wb_ready;
   reg_addr_t wb_rd;
   xlen_t     wb_data;

   logic      mdu_valid;
   logic      mdu_ready;
   reg_addr_t mdu_rd;
   xlen_t     mdu_data;

   logic      iss_valid;
   reg_addr_t iss_rd;

   reg_addr_t rs1_addr;
   reg_addr_t rs2_addr;
   logic      rs1_busy;
   logic      rs2_busy;

   logic      rf_wr_en;
   reg_addr_t rf_rd_addr;
   xlen_t     rf_wr_data;
   logic      sb_err;

   modport master (
      output wb_valid, wb_rd, wb_data,
      output mdu_valid, mdu_rd, mdu_data,
      output iss_valid, iss_rd,
      output rs1_addr, rs2_addr,
      input  wb_ready, mdu_ready, rs1_busy, rs2_busy,
      input  rf_wr_en, rf_rd_addr, rf_wr_data, sb_err
   );

   modport slave (
      input  wb_valid, wb_rd, wb_data,
      input  mdu_valid, mdu_rd, mdu_data,
      input  iss_valid, iss_rd,
      input  rs1_addr, rs2_addr,
      output wb_ready, mdu_ready, rs1_busy, rs2_busy,
      output rf_wr_en, rf_rd_addr, rf_wr_data, sb_err
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for in-flight MDU destinations, two hazard read ports
// and combinational detection of scoreboard protocol violations.
module rf_scoreboard
   import rf_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      set_en_i,
   input  reg_addr_t set_addr_i,
   input  logic      clr_en_i,
   input  reg_addr_t clr_addr_i,
   input  reg_addr_t rd1_addr_i,
   input  reg_addr_t rd2_addr_i,
   output logic      rd1_busy_o,
   output logic      rd2_busy_o,
   input  logic      wb_chk_en_i,
   input  reg_addr_t wb_chk_addr_i,
   input  logic      mdu_chk_en_i,
   input  reg_addr_t mdu_chk_addr_i,
   output logic      viol_o
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [NREGS-1:0] set_vec_s;
   logic [NREGS-1:0] clr_vec_s;
   logic             iss_viol_s;
   logic             wb_viol_s;
   logic             mdu_viol_s;

   // Next busy vector: a set on the same edge as a clear keeps the bit busy
   always_comb begin
      set_vec_s = reg_onehot(set_addr_i, set_en_i);
      clr_vec_s = reg_onehot(clr_addr_i, clr_en_i);
      busy_d    = set_vec_s | (busy_q & ~clr_vec_s);
   end

   // Busy vector register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Hazard read ports and violation detection against the current busy state
   always_comb begin
      rd1_busy_o = busy_q[rd1_addr_i];
      rd2_busy_o = busy_q[rd2_addr_i];
      iss_viol_s = set_en_i && (set_addr_i != '0) && busy_q[set_addr_i] && !clr_vec_s[set_addr_i];
      wb_viol_s  = wb_chk_en_i && (wb_chk_addr_i != '0) && busy_q[wb_chk_addr_i];
      mdu_viol_s = mdu_chk_en_i && (mdu_chk_addr_i != '0) && !busy_q[mdu_chk_addr_i];
      viol_o     = iss_viol_s || wb_viol_s || mdu_viol_s;
   end

endmodule

// File: rtl/rf_wr_scheduler.sv
// Register-file write-port scheduler: WB-priority arbiter with MDU starvation
// guard, registered write port, sticky scoreboard error and busy scoreboard.
module rf_wr_scheduler
   import rf_ctrl_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input logic              clk,
   input logic              reset,
   rf_wr_scheduler_if.slave bus
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t CNT_MAX = cnt_t'(STARVE_LIMIT);

   cnt_t      starve_q;
   cnt_t      starve_d;
   logic      force_s;
   logic      grant_mdu_s;
   logic      grant_wb_s;

   logic      wr_en_q;
   logic      wr_en_d;
   reg_addr_t addr_q;
   reg_addr_t addr_d;
   xlen_t     data_q;
   xlen_t     data_d;
   src_t      src_q;
   src_t      src_d;
   logic      err_q;
   logic      err_d;

   logic      clr_en_s;
   logic      viol_s;

   // WB normally wins; the MDU is forced through once it has been denied STARVE_LIMIT times
   always_comb begin
      force_s     = bus.mdu_valid && (starve_q == CNT_MAX);
      grant_mdu_s = bus.mdu_valid && (force_s || !bus.wb_valid);
      grant_wb_s  = bus.wb_valid && !grant_mdu_s;
   end

   // Starvation counter next state: saturating count of consecutive MDU denials
   always_comb begin
      starve_d = '0;
      if (bus.mdu_valid && !grant_mdu_s) begin
         if (starve_q == CNT_MAX) begin
            starve_d = starve_q;
         end else begin
            starve_d = starve_q + cnt_t'(1);
         end
      end else begin
         starve_d = '0;
      end
   end

   // Write-port next state: address/data/source hold when nothing is granted
   always_comb begin
      wr_en_d = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      src_d   = src_q;
      if (grant_mdu_s) begin
         wr_en_d = (bus.mdu_rd != '0);
         addr_d  = bus.mdu_rd;
         data_d  = bus.mdu_data;
         src_d   = SRC_MDU;
      end else if (grant_wb_s) begin
         wr_en_d = (bus.wb_rd != '0);
         addr_d  = bus.wb_rd;
         data_d  = bus.wb_data;
         src_d   = SRC_WB;
      end else begin
         wr_en_d = 1'b0;
      end
      err_d = err_q || viol_s;
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q <= '0;
         wr_en_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         src_q    <= SRC_WB;
         err_q    <= 1'b0;
      end else begin
         starve_q <= starve_d;
         wr_en_q  <= wr_en_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         src_q    <= src_d;
         err_q    <= err_d;
      end
   end

   // A busy bit retires at the end of the cycle its MDU result is written
   assign clr_en_s = wr_en_q && (src_q == SRC_MDU);

   rf_scoreboard u_scoreboard (
      .clk            (clk),
      .reset          (reset),
      .set_en_i       (bus.iss_valid),
      .set_addr_i     (bus.iss_rd),
      .clr_en_i       (clr_en_s),
      .clr_addr_i     (addr_q),
      .rd1_addr_i     (bus.rs1_addr),
      .rd2_addr_i     (bus.rs2_addr),
      .rd1_busy_o     (bus.rs1_busy),
      .rd2_busy_o     (bus.rs2_busy),
      .wb_chk_en_i    (grant_wb_s),
      .wb_chk_addr_i  (bus.wb_rd),
      .mdu_chk_en_i   (grant_mdu_s),
      .mdu_chk_addr_i (bus.mdu_rd),
      .viol_o         (viol_s)
   );

   assign bus.wb_ready   = grant_wb_s;
   assign bus.mdu_ready  = grant_mdu_s;
   assign bus.rf_wr_en   = wr_en_q;
   assign bus.rf_rd_addr = addr_q;
   assign bus.rf_wr_data = data_q;
   assign bus.sb_err     = err_q;

endmodule

// File: tb/tb_rf_wr_scheduler.sv
// Directed scenarios plus a randomized run of rf_wr_scheduler against a
// behavioural model of the arbitration, write port and scoreboard rules.
module tb_rf_wr_scheduler;
   import rf_ctrl_pkg::*;

   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rf_wr_scheduler_if bus();

   rf_wr_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   bit          m_busy [NREGS];
   int          m_starve;
   bit          m_wr_en;
   int          m_addr;
   logic [31:0] m_data;
   bit          m_from_mdu;
   bit          m_err;

   function automatic bit exp_mdu_ready();
      return bus.mdu_valid && ((m_starve >= LIMIT) || !bus.wb_valid);
   endfunction

   function automatic bit exp_wb_ready();
      return bus.wb_valid && !exp_mdu_ready();
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
      m_starve = 0; m_wr_en = 1'b0; m_addr = 0; m_data = 32'h0; m_from_mdu = 1'b0; m_err = 1'b0;
   endtask

   task automatic idle();
      bus.wb_valid = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;
      bus.mdu_valid = 1'b0; bus.mdu_rd = 5'd0; bus.mdu_data = 32'h0;
      bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
      bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
   endtask

   // One clock: model consumes this cycle's inputs, DUT takes the edge, return at negedge
   task automatic tick();
      bit gm, gw, err, iss_v, mdu_v;
      int clr, iss_r, wb_r, mdu_r;
      logic [31:0] wb_dv, mdu_dv;
      gm = exp_mdu_ready(); gw = exp_wb_ready();
      iss_v = bus.iss_valid; iss_r = int'(bus.iss_rd);
      wb_r = int'(bus.wb_rd); wb_dv = bus.wb_data;
      mdu_v = bus.mdu_valid; mdu_r = int'(bus.mdu_rd); mdu_dv = bus.mdu_data;
      clr = (m_wr_en && m_from_mdu) ? m_addr : 0;
      err = 1'b0;
      if (iss_v && iss_r != 0 && m_busy[iss_r] && clr != iss_r) err = 1'b1;
      if (gw && wb_r != 0 && m_busy[wb_r]) err = 1'b1;
      if (gm && mdu_r != 0 && !m_busy[mdu_r]) err = 1'b1;
      @(posedge clk);
      m_err = m_err | err;
      if (clr != 0) m_busy[clr] = 1'b0;
      if (iss_v && iss_r != 0) m_busy[iss_r] = 1'b1;
      if (mdu_v && !gm) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      else m_starve = 0;
      if (gm) begin
         m_wr_en = (mdu_r != 0); m_addr = mdu_r; m_data = mdu_dv; m_from_mdu = 1'b1;
      end else if (gw) begin
         m_wr_en = (wb_r != 0); m_addr = wb_r; m_data = wb_dv; m_from_mdu = 1'b0;
      end else begin
         m_wr_en = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h1234_5678;
      tick();
      bus.wb_rd = 5'd6; bus.wb_data = 32'hCAFE_0006;
      tick();
      idle(); bus.rs1_addr = 5'd3; #1;
      n_tests++; if (bus.rf_wr_en !== 1'b1 || bus.rs1_busy !== 1'b1 || bus.sb_err !== 1'b1) begin
         n_fail++; $display("FAIL reset_setup: wr_en=%0b busy3=%0b sb_err=%0b, required 1 1 1", bus.rf_wr_en, bus.rs1_busy, bus.sb_err);
      end
      reset = 1'b1; #1;
      n_tests++; if (bus.rf_wr_en !== 1'b0 || bus.rf_rd_addr !== 5'd0 || bus.rf_wr_data !== 32'h0) begin
         n_fail++; $display("FAIL reset_wport: en=%0b addr=%0d data=%h, required 0 0 0", bus.rf_wr_en, bus.rf_rd_addr, bus.rf_wr_data);
      end
      n_tests++; if (bus.sb_err !== 1'b0 || bus.rs1_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_sb: sb_err=%0b busy3=%0b, required 0 0", bus.sb_err, bus.rs1_busy);
      end
      model_reset();
      @(negedge clk); reset = 1'b0;
      tick(); #1;
      n_tests++; if (bus.rf_wr_en !== 1'b0 || bus.rs1_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: en=%0b busy3=%0b, required 0 0", bus.rf_wr_en, bus.rs1_busy);
      end
   endtask

   task automatic test_wb_only();
      idle();
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEAD_BEEF; #1;
      n_tests++; if (bus.wb_ready !== 1'b1 || bus.mdu_ready !== 1'b0) begin
         n_fail++; $display("FAIL wb_only_ready: wb=%0b mdu=%0b, required 1 0", bus.wb_ready, bus.mdu_ready);
      end
      tick(); idle(); #1;
      n_tests++; if (bus.rf_wr_en !== 1'b1 || bus.rf_rd_addr !== 5'd5 || bus.rf_wr_data !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL wb_only_write: en=%0b addr=%0d data=%h, required 1 5 deadbeef", bus.rf_wr_en, bus.rf_rd_addr, bus.rf_wr_data);
      end
      tick(); #1;
      n_tests++; if (bus.rf_wr_en !== 1'b0 || bus.rf_wr_data !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL wb_only_hold: en=%0b data=%h, required 0 deadbeef", bus.rf_wr_en, bus.rf_wr_data);
      end
   endtask

   task automatic test_starvation();
      bit exp_m;
      idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd4; tick();
      bus.iss_rd = 5'd8; tick();
      idle();
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd6;
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd4; bus.mdu_data = 32'hA5A5_0004;
      for (int c = 0; c < 10; c++) begin
         bus.wb_data = 32'h0000_0100 + c;
         if (c == 5) begin bus.mdu_rd = 5'd8; bus.mdu_data = 32'hA5A5_0008; end
         #1;
         exp_m = (c == 4) || (c == 9);
         n_tests++; if (bus.mdu_ready !== exp_m || bus.wb_ready !== !exp_m) begin
            n_fail++; $display("FAIL starve_c%0d: mdu=%0b wb=%0b, required %0b %0b", c, bus.mdu_ready, bus.wb_ready, exp_m, !exp_m);
         end
         if (c == 5) begin
            n_tests++; if (bus.rf_wr_en !== 1'b1 || bus.rf_rd_addr !== 5'd4 || bus.rf_wr_data !== 32'hA5A5_0004) begin
               n_fail++; $display("FAIL starve_mdu_write: en=%0b addr=%0d data=%h, required 1 4 a5a50004", bus.rf_wr_en, bus.rf_rd_addr, bus.rf_wr_data);
            end
         end
         tick();
      end
      idle(); tick(); tick(); bus.rs1_addr = 5'd4; bus.rs2_addr = 5'd8; #1;
      n_tests++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 || bus.sb_err !== 1'b0) begin
         n_fail++; $display("FAIL starve_end: busy4=%0b busy8=%0b sb_err=%0b, required 0 0 0", bus.rs1_busy, bus.rs2_busy, bus.sb_err);
      end
   endtask

   task automatic test_scoreboard();
      idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd7; #1;
      n_tests++; if (bus.rs1_busy !== 1'b0) begin
         n_fail++; $display("FAIL sb_pre_issue: busy7=%0b, required 0", bus.rs1_busy);
      end
      tick(); bus.iss_valid = 1'b0; #1;
      n_tests++; if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1) begin
         n_fail++; $display("FAIL sb_after_issue: rs1=%0b rs2=%0b, required 1 1", bus.rs1_busy, bus.rs2_busy);
      end
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_data = 32'h0000_0077; #1;
      n_tests++; if (bus.mdu_ready !== 1'b1) begin
         n_fail++; $display("FAIL sb_mdu_ready: got %0b, required 1", bus.mdu_ready);
      end
      tick(); bus.mdu_valid = 1'b0; #1;
      n_tests++; if (bus.rf_wr_en !== 1'b1 || bus.rf_rd_addr !== 5'd7 || bus.rs1_busy !== 1'b1) begin
         n_fail++; $display("FAIL sb_write_cycle: en=%0b addr=%0d busy7=%0b, required 1 7 1", bus.rf_wr_en, bus.rf_rd_addr, bus.rs1_busy);
      end
      tick(); #1;
      n_tests++; if (bus.rs1_busy !== 1'b0 || bus.rf_wr_en !== 1'b0) begin
         n_fail++; $display("FAIL sb_cleared: busy7=%0b en=%0b, required 0 0", bus.rs1_busy, bus.rf_wr_en);
      end
   endtask

   task automatic test_x0();
      idle(); bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF_FFFF; #1;
      n_tests++; if (bus.wb_ready !== 1'b1) begin
         n_fail++; $display("FAIL x0_ready: got %0b, required 1", bus.wb_ready);
      end
      tick(); idle(); #1;
      n_tests++; if (bus.rf_wr_en !== 1'b0) begin
         n_fail++; $display("FAIL x0_wr_en: got %0b, required 0", bus.rf_wr_en);
      end
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
      tick(); tick(); idle(); #1;
      n_tests++; if (bus.rs1_busy !== 1'b0 || bus.sb_err !== 1'b0) begin
         n_fail++; $display("FAIL x0_busy: busy0=%0b sb_err=%0b, required 0 0", bus.rs1_busy, bus.sb_err);
      end
   endtask

   task automatic test_set_wins();
      idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; tick();
      idle(); bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h0000_0099; tick();
      idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; bus.rs1_addr = 5'd9; tick();
      bus.iss_valid = 1'b0; #1;
      n_tests++; if (bus.rs1_busy !== 1'b1 || bus.sb_err !== 1'b0) begin
         n_fail++; $display("FAIL setwins_busy: busy9=%0b sb_err=%0b, required 1 0", bus.rs1_busy, bus.sb_err);
      end
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h0BAD_0009; #1;
      n_tests++; if (bus.wb_ready !== 1'b1) begin
         n_fail++; $display("FAIL setwins_wb_ready: got %0b, required 1", bus.wb_ready);
      end
      tick(); idle(); #1;
      n_tests++; if (bus.sb_err !== 1'b1 || bus.rf_wr_data !== 32'h0BAD_0009) begin
         n_fail++; $display("FAIL setwins_err: sb_err=%0b data=%h, required 1 0bad0009", bus.sb_err, bus.rf_wr_data);
      end
      repeat (3) tick();
      #1;
      n_tests++; if (bus.sb_err !== 1'b1) begin
         n_fail++; $display("FAIL setwins_sticky: sb_err=%0b, required 1", bus.sb_err);
      end
      apply_reset();
   endtask

   task automatic test_random();
      bit inflight [NREGS];
      bit last_wb_g, last_mdu_g;
      int r, start;
      for (int i = 0; i < NREGS; i++) inflight[i] = 1'b0;
      idle(); last_wb_g = 1'b0; last_mdu_g = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!bus.mdu_valid || last_mdu_g) begin
            bus.mdu_valid = 1'b0;
            if ($urandom_range(0, 99) < 50) begin
               start = $urandom_range(1, 7);
               for (int k = 0; k < 7; k++) begin
                  r = ((start - 1 + k) % 7) + 1;
                  if (!bus.mdu_valid && inflight[r]) begin
                     inflight[r] = 1'b0;
                     bus.mdu_valid = 1'b1; bus.mdu_rd = 5'(r); bus.mdu_data = $urandom;
                  end
               end
            end
         end
         if (!bus.wb_valid || last_wb_g) begin
            bus.wb_valid = ($urandom_range(0, 99) < 65);
            bus.wb_rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(8, 15));
            bus.wb_data = $urandom;
         end
         r = $urandom_range(1, 7);
         bus.iss_valid = ($urandom_range(0, 99) < 40) && !m_busy[r] && !inflight[r];
         bus.iss_rd = 5'(r);
         if (bus.iss_valid) inflight[r] = 1'b1;
         bus.rs1_addr = 5'($urandom_range(0, 15));
         bus.rs2_addr = 5'($urandom_range(0, 15));
         #1;
         n_tests++; if (bus.wb_ready !== exp_wb_ready() || bus.mdu_ready !== exp_mdu_ready()) begin
            n_fail++; $display("FAIL rnd_grant c%0d: wb=%0b mdu=%0b, required %0b %0b", cyc, bus.wb_ready, bus.mdu_ready, exp_wb_ready(), exp_mdu_ready());
         end
         n_tests++; if (bus.rs1_busy !== m_busy[bus.rs1_addr] || bus.rs2_busy !== m_busy[bus.rs2_addr]) begin
            n_fail++; $display("FAIL rnd_busy c%0d: rs1=%0b rs2=%0b, required %0b %0b", cyc, bus.rs1_busy, bus.rs2_busy, m_busy[bus.rs1_addr], m_busy[bus.rs2_addr]);
         end
         n_tests++; if (bus.rf_wr_en !== m_wr_en || bus.rf_rd_addr !== 5'(m_addr) || bus.rf_wr_data !== m_data) begin
            n_fail++; $display("FAIL rnd_wport c%0d: en=%0b addr=%0d data=%h, required %0b %0d %h", cyc, bus.rf_wr_en, bus.rf_rd_addr, bus.rf_wr_data, m_wr_en, m_addr, m_data);
         end
         n_tests++; if (bus.sb_err !== m_err) begin
            n_fail++; $display("FAIL rnd_sb_err c%0d: got %0b, required %0b", cyc, bus.sb_err, m_err);
         end
         last_wb_g = exp_wb_ready(); last_mdu_g = exp_mdu_ready();
         tick();
      end
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_wb_only();
      test_starvation();
      test_scoreboard();
      test_x0();
      test_set_wins();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
